crc_fault_engine: RTL and testbench
===================================

Name: crc_fault_engine

Overview:
Parametrised parallel CRC engine with built-in fault injection and a fault-free golden shadow CRC. The engine accepts framed data beats over a valid/ready stream and returns faulted and golden CRCs per frame, plus a mismatch flag and saturating frame/mismatch counters. It is the production successor of the fixed 16-bit fault-injectable CRC and serves fault-coverage sweeps and CRC error-detection characterisation.

Parameters:
DATA_W, 16, data bits consumed per accepted beat (>=1)
CRC_W, 16, CRC register width (>=2)
POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term
INIT, 16'hFFFF, CRC register value at frame start
XOR_OUT, 16'h0000, final XOR applied to the result
FAULT_W (localparam), max(DATA_W, CRC_W), fault vector width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  engine can accept a beat
s_data  in  DATA_W  input beat
s_last  in  1  beat is the last of its frame
fault_mode  in  2  00 none, 01 stuck-at, 10 persistent flip, 11 one-shot flip
fault_target  in  1  0 = fault s_data, 1 = fault CRC state
fault_mask  in  FAULT_W  bits to corrupt (LSB-aligned to the target width)
fault_value  in  FAULT_W  stuck-at values under the mask
m_valid  out  1  result valid
m_ready  in  1  result consumed
m_crc  out  CRC_W  faulted CRC, final XOR applied
m_golden  out  CRC_W  fault-free CRC, final XOR applied
m_mismatch  out  1  m_crc != m_golden
frame_cnt  out  16  frames delivered, saturating
mismatch_cnt  out  16  delivered frames with a mismatch, saturating

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; crc_f and crc_g = INIT; m_valid, m_mismatch, m_crc, m_golden, frame_cnt, mismatch_cnt = 0; one-shot disarmed.
- FSM states:
  - IDLE: s_ready=1. An accepted beat moves to ACCUM, or to HOLD if s_last=1.
  - ACCUM: s_ready=1. An accepted beat with s_last=1 moves to HOLD.
  - HOLD: s_ready=0, m_valid=1. When m_ready=1, go to IDLE, reload both CRCs to INIT and clear m_valid.
- Accepted beat means s_valid & s_ready. Without an accepted beat, all state holds.
- CRC step: MSB-first, non-reflected, DATA_W single-bit steps unrolled per beat, s_data[DATA_W-1] first.
  - Per bit: fb = crc[CRC_W-1] ^ d[i]; crc = (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_W.
- Latency: on the last accepted beat, m_crc, m_golden and m_mismatch are registered and m_valid asserts the next cycle. These outputs stay stable for the whole of HOLD.
- Fault application (combinational, before the step, on the faulted path only):
  - Stuck-at: x' = (x & ~mask) | (value & mask).
  - Flip: x' = x ^ mask.
  - The mask is truncated to the target width. fault_target=1 corrupts the crc_f value fed into the step; the stored register is not rewritten.
- Golden path always uses the uncorrupted s_data and crc_g.
- fault_* inputs are sampled per accepted beat. Changes mid-frame take effect on the next accepted beat.
- One-shot mode:
  - Arms on any cycle where fault_mode becomes 11 from another value.
  - Corrupts exactly the next accepted beat, then disarms.
  - Re-arming requires leaving mode 11 and re-entering it. While mode 11 is disarmed, it behaves as mode 00.
- Counters: update on m_valid & m_ready. frame_cnt += 1, saturating at 16'hFFFF; mismatch_cnt += 1 if m_mismatch, saturating.
- Reset mid-frame: the partial frame is discarded and the counters are cleared.

Decomposition:
- Package crc_fault_pkg holds:
  - fault_mode_e enum (FM_NONE, FM_STUCK, FM_FLIP, FM_ONESHOT)
  - state_e enum (IDLE, ACCUM, HOLD)
  - the apply_fault function
- Sub-module crc_step_par: purely combinational next-CRC for one beat, parametrised by DATA_W, CRC_W and POLY. It is instantiated twice, once for the faulted path and once for the golden path.

Test Plan:
- DATA_W=8, defaults, mode 00, beats 0x31..0x39 with s_last on 0x39 -> m_crc = m_golden = 16'h29B1, m_mismatch=0, frame_cnt=1.
- DATA_W=16, single beat 0xA5A5 with s_last, mode 01, target 0, mask 0x0001, value 0x0001 (matches the data bit) -> m_crc=m_golden, mismatch_cnt=0. Same beat with value 0x0000 -> m_crc ^ m_golden = 16'h1021, m_mismatch=1, mismatch_cnt=1.
- Mode 11, target 1, mask 0x8000, 3-beat frame -> only the first beat is corrupted, m_mismatch=1. A second frame without leaving mode 11 -> m_mismatch=0.
- Result backpressure: m_ready held low 3 cycles after m_valid -> s_ready=0, m_crc stable, a pending s_valid beat is not accepted. m_ready=1 -> IDLE next cycle, s_ready=1.
- Reset asserted after 2 beats of a frame -> all outputs 0 immediately. A fresh frame after release matches the golden model from INIT.
- Force frame_cnt to 16'hFFFF via 65535 frames (or a bench backdoor), then deliver one more frame -> frame_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/crc_fault_pkg.sv
// rtl/crc_fault_pkg.sv - shared types and fault helper for crc_fault_engine
//
// Purpose : fault mode / FSM state enums and the apply_fault helper.
//           The helper works on a fixed MAX_W-wide word. Callers zero-extend
//           their operand and truncate the result back to the target width,
//           so mask bits above the target width have no effect.
// Ports   : none (package)
package crc_fault_pkg;

  // Widest data or CRC word the fault helper can handle.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    FM_NONE    = 2'b00,
    FM_STUCK   = 2'b01,
    FM_FLIP    = 2'b10,
    FM_ONESHOT = 2'b11
  } fault_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // FM_ONESHOT arrives here only while the one-shot is live. The caller
  // demotes a disarmed one-shot to FM_NONE before calling.
  function automatic logic [MAX_W-1:0] apply_fault(
    input fault_mode_e      mode,
    input logic [MAX_W-1:0] x,
    input logic [MAX_W-1:0] mask,
    input logic [MAX_W-1:0] value
  );
    logic [MAX_W-1:0] r;
    case (mode)
      FM_STUCK:   r = (x & ~mask) | (value & mask);
      FM_FLIP:    r = x ^ mask;
      FM_ONESHOT: r = x ^ mask;
      default:    r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/crc_step_par.sv
// rtl/crc_step_par.sv - combinational one-beat parallel CRC update
//
// Purpose : next CRC after consuming DATA_W data bits, MSB first, non-reflected.
// Ports   : i_crc  [CRC_W]  current CRC register value
//           i_data [DATA_W] beat data, i_data[DATA_W-1] consumed first
//           o_crc  [CRC_W]  CRC after the whole beat
module crc_step_par
  import crc_fault_pkg::*;
#(
  parameter int               DATA_W = 16,
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021
) (
  input  logic [CRC_W-1:0]  i_crc,
  input  logic [DATA_W-1:0] i_data,
  output logic [CRC_W-1:0]  o_crc
);

  logic [CRC_W-1:0] w_c;
  logic             w_fb;

  // The loop unrolls into DATA_W chained single-bit LFSR steps.
  always_comb begin
    w_c  = i_crc;
    w_fb = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      w_fb = w_c[CRC_W-1] ^ i_data[i];
      w_c  = {w_c[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/crc_fault_engine.sv
// rtl/crc_fault_engine.sv - fault-injectable parallel CRC engine with golden shadow
//
// Purpose : accumulates framed beats into a faulted CRC and a fault-free golden
//           CRC, presents both per frame with a mismatch flag, and counts
//           delivered frames and mismatching frames (saturating).
// Ports   : clk                    rising-edge clock
//           reset                  async assert, sync release, active low
//           s_valid/s_ready        input beat handshake
//           s_data [DATA_W]        input beat, s_last marks the end of a frame
//           fault_mode [2]         00 none, 01 stuck-at, 10 flip, 11 one-shot flip
//           fault_target           0 corrupt s_data, 1 corrupt CRC state
//           fault_mask/value [FAULT_W] corruption mask and stuck-at values
//           m_valid/m_ready        result handshake
//           m_crc/m_golden [CRC_W] faulted / golden CRC, XOR_OUT applied
//           m_mismatch             m_crc != m_golden
//           frame_cnt/mismatch_cnt [16] saturating counters
module crc_fault_engine
  import crc_fault_pkg::*;
#(
  parameter int               DATA_W  = 16,
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h1021,
  parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
  localparam int              FAULT_W = (DATA_W > CRC_W) ? DATA_W : CRC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  input  logic [1:0]         fault_mode,
  input  logic               fault_target,
  input  logic [FAULT_W-1:0] fault_mask,
  input  logic [FAULT_W-1:0] fault_value,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CRC_W-1:0]   m_crc,
  output logic [CRC_W-1:0]   m_golden,
  output logic               m_mismatch,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        mismatch_cnt
);

  // Reset synchroniser: assertion clears everything at once, release is
  // retimed to clk so all state leaves reset on the same edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // FSM
  state_e r_state;
  state_e w_state_nxt;
  logic   w_s_ready;
  logic   w_m_valid;
  logic   w_beat_acc;
  logic   w_result_acc;

  assign w_beat_acc   = s_valid & w_s_ready;
  assign w_result_acc = w_m_valid & m_ready;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_beat_acc) w_state_nxt = s_last ? HOLD : ACCUM;
      ACCUM:   if (w_beat_acc && s_last) w_state_nxt = HOLD;
      HOLD:    if (m_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_s_ready = 1'b0;
    w_m_valid = 1'b0;
    case (r_state)
      IDLE, ACCUM: w_s_ready = 1'b1;
      HOLD:        w_m_valid = 1'b1;
      default: begin
        w_s_ready = 1'b0;
        w_m_valid = 1'b0;
      end
    endcase
  end

  // One-shot tracking. The one-shot is live on the cycle the mode enters 11
  // (edge against last cycle's mode) and stays live until a beat is accepted
  // or the mode leaves 11.
  fault_mode_e r_prev_mode;
  logic        r_os_armed;
  fault_mode_e w_mode_in;
  fault_mode_e w_mode_eff;
  fault_mode_e w_mode_data;
  fault_mode_e w_mode_crc;
  logic        w_os_live;

  assign w_mode_in = fault_mode_e'(fault_mode);
  assign w_os_live = (w_mode_in == FM_ONESHOT) &&
                     (r_os_armed || (r_prev_mode != FM_ONESHOT));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prev_mode <= FM_NONE;
      r_os_armed  <= 1'b0;
    end else begin
      r_prev_mode <= w_mode_in;
      r_os_armed  <= w_os_live & ~w_beat_acc;
    end
  end

  always_comb begin
    w_mode_eff = w_mode_in;
    if ((w_mode_in == FM_ONESHOT) && !w_os_live) w_mode_eff = FM_NONE;
  end

  assign w_mode_data = fault_target ? FM_NONE : w_mode_eff;
  assign w_mode_crc  = fault_target ? w_mode_eff : FM_NONE;

  // Faulted path operands. A state fault only alters what feeds the step;
  // r_crc_f itself is never overwritten by the fault.
  logic [CRC_W-1:0]  r_crc_f;
  logic [CRC_W-1:0]  r_crc_g;
  logic [DATA_W-1:0] w_data_f;
  logic [CRC_W-1:0]  w_crc_in_f;
  logic [CRC_W-1:0]  w_crc_nxt_f;
  logic [CRC_W-1:0]  w_crc_nxt_g;

  assign w_data_f   = DATA_W'(apply_fault(w_mode_data, MAX_W'(s_data),
                                          MAX_W'(fault_mask), MAX_W'(fault_value)));
  assign w_crc_in_f = CRC_W'(apply_fault(w_mode_crc, MAX_W'(r_crc_f),
                                         MAX_W'(fault_mask), MAX_W'(fault_value)));

  crc_step_par #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) u_step_f (
    .i_crc  (w_crc_in_f),
    .i_data (w_data_f),
    .o_crc  (w_crc_nxt_f)
  );

  crc_step_par #(
    .DATA_W (DATA_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) u_step_g (
    .i_crc  (r_crc_g),
    .i_data (s_data),
    .o_crc  (w_crc_nxt_g)
  );

  // CRC state and result registers
  logic [CRC_W-1:0] r_m_crc;
  logic [CRC_W-1:0] r_m_golden;
  logic             r_m_mismatch;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_crc_f      <= INIT;
      r_crc_g      <= INIT;
      r_m_crc      <= '0;
      r_m_golden   <= '0;
      r_m_mismatch <= 1'b0;
    end else if (w_beat_acc) begin
      r_crc_f <= w_crc_nxt_f;
      r_crc_g <= w_crc_nxt_g;
      if (s_last) begin
        r_m_crc      <= w_crc_nxt_f ^ XOR_OUT;
        r_m_golden   <= w_crc_nxt_g ^ XOR_OUT;
        r_m_mismatch <= (w_crc_nxt_f != w_crc_nxt_g);
      end
    end else if (w_result_acc) begin
      r_crc_f <= INIT;
      r_crc_g <= INIT;
    end
  end

  // Saturating counters
  logic [15:0] r_frame_cnt;
  logic [15:0] r_mismatch_cnt;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_frame_cnt    <= 16'h0000;
      r_mismatch_cnt <= 16'h0000;
    end else if (w_result_acc) begin
      if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_m_mismatch && (r_mismatch_cnt != 16'hFFFF))
        r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
    end
  end

  assign s_ready      = w_s_ready;
  assign m_valid      = w_m_valid;
  assign m_crc        = r_m_crc;
  assign m_golden     = r_m_golden;
  assign m_mismatch   = r_m_mismatch;
  assign frame_cnt    = r_frame_cnt;
  assign mismatch_cnt = r_mismatch_cnt;

endmodule

// File: tb/tb_crc_fault_engine.sv
// tb/tb_crc_fault_engine.sv - self-checking bench for crc_fault_engine
module tb_crc_fault_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  fault_mode;
  logic        fault_target;
  logic [15:0] fault_mask;
  logic [15:0] fault_value;

  // 16-bit-beat instance
  logic        b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_mismatch;
  logic [15:0] b_s_data, b_m_crc, b_m_golden, b_frame_cnt, b_mismatch_cnt;

  // 8-bit-beat instance
  logic        a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_mismatch;
  logic [7:0]  a_s_data;
  logic [15:0] a_m_crc, a_m_golden, a_frame_cnt, a_mismatch_cnt;

  crc_fault_engine u_b (
    .clk (clk), .reset (reset),
    .s_valid (b_s_valid), .s_ready (b_s_ready), .s_data (b_s_data), .s_last (b_s_last),
    .fault_mode (fault_mode), .fault_target (fault_target),
    .fault_mask (fault_mask), .fault_value (fault_value),
    .m_valid (b_m_valid), .m_ready (b_m_ready), .m_crc (b_m_crc), .m_golden (b_m_golden),
    .m_mismatch (b_m_mismatch), .frame_cnt (b_frame_cnt), .mismatch_cnt (b_mismatch_cnt)
  );

  crc_fault_engine #(.DATA_W(8)) u_a (
    .clk (clk), .reset (reset),
    .s_valid (a_s_valid), .s_ready (a_s_ready), .s_data (a_s_data), .s_last (a_s_last),
    .fault_mode (fault_mode), .fault_target (fault_target),
    .fault_mask (fault_mask), .fault_value (fault_value),
    .m_valid (a_m_valid), .m_ready (a_m_ready), .m_crc (a_m_crc), .m_golden (a_m_golden),
    .m_mismatch (a_m_mismatch), .frame_cnt (a_frame_cnt), .mismatch_cnt (a_mismatch_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: CRC register after a beat is (s * x^dw + d * x^16) mod G,
  // G = x^16 + 0x1021, evaluated by polynomial long division.
  function automatic logic [15:0] crc_step(input logic [15:0] s, input logic [63:0] d,
                                           input int dw);
    logic [63:0] v;
    v = (64'(s) << dw) ^ (d << 16);
    for (int i = dw + 15; i >= 16; i--)
      if (v[i]) v = v ^ (64'h1_1021 << (i - 16));
    return v[15:0];
  endfunction

  function automatic logic [15:0] fault16(input int m, input logic [15:0] x,
                                          input logic [15:0] mk, input logic [15:0] v);
    case (m)
      1:       return (x & ~mk) | (v & mk);
      2, 3:    return x ^ mk;
      default: return x;
    endcase
  endfunction

  // Model state
  int          prev_mode = 0;
  bit          armed = 1'b0;
  logic [15:0] exp_frames = 16'h0;
  logic [15:0] exp_mm = 16'h0;
  logic [15:0] a_frames = 16'h0;

  logic [15:0] q_data[$];
  int          q_mode[$];
  logic        q_tgt[$];
  logic [15:0] q_mask[$];
  logic [15:0] q_val[$];
  logic [7:0]  q8[$];

  task automatic set_fault(input int m, input logic t, input logic [15:0] mk,
                           input logic [15:0] v);
    if (m == 3 && prev_mode != 3) armed = 1'b1;
    if (m != 3) armed = 1'b0;
    prev_mode    = m;
    fault_mode   = 2'(m);
    fault_target = t;
    fault_mask   = mk;
    fault_value  = v;
  endtask

  task automatic push_beat(input logic [15:0] d, input int m, input logic t,
                           input logic [15:0] mk, input logic [15:0] v);
    q_data.push_back(d); q_mode.push_back(m); q_tgt.push_back(t);
    q_mask.push_back(mk); q_val.push_back(v);
  endtask

  task automatic frame16(input int hold);
    logic [15:0] sf, sg, d, df, sfi;
    int          n, m, eff;
    logic        mm;
    sf = 16'hFFFF;
    sg = 16'hFFFF;
    n  = q_data.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      set_fault(q_mode[k], q_tgt[k], q_mask[k], q_val[k]);
      m   = q_mode[k];
      eff = m;
      if (m == 3) begin
        eff   = armed ? 3 : 0;
        armed = 1'b0;
      end
      d   = q_data[k];
      df  = d;
      sfi = sf;
      if (q_tgt[k]) sfi = fault16(eff, sf, q_mask[k], q_val[k]);
      else          df  = fault16(eff, d, q_mask[k], q_val[k]);
      sf = crc_step(sfi, 64'(df), 16);
      sg = crc_step(sg, 64'(d), 16);
      b_s_valid = 1'b1;
      b_s_data  = d;
      b_s_last  = (k == n - 1);
      #1 check("s_ready_beat", 32'(b_s_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    b_s_valid = 1'b0;
    b_s_last  = 1'b0;
    mm = (sf != sg);
    check("m_valid", 32'(b_m_valid), 32'd1);
    check("m_crc", 32'(b_m_crc), 32'(sf));
    check("m_golden", 32'(b_m_golden), 32'(sg));
    check("m_mismatch", 32'(b_m_mismatch), 32'(mm));
    for (int c = 0; c < hold; c++) begin
      b_s_valid = 1'b1;
      b_s_last  = 1'b1;
      b_s_data  = 16'($urandom);
      #1 check("hold_s_ready", 32'(b_s_ready), 32'd0);
      @(negedge clk);
      check("hold_m_valid", 32'(b_m_valid), 32'd1);
      check("hold_m_crc", 32'(b_m_crc), 32'(sf));
      check("hold_m_golden", 32'(b_m_golden), 32'(sg));
    end
    b_s_valid = 1'b0;
    b_s_last  = 1'b0;
    b_m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_m_ready = 1'b0;
    if (exp_frames != 16'hFFFF) exp_frames = exp_frames + 16'd1;
    if (mm && exp_mm != 16'hFFFF) exp_mm = exp_mm + 16'd1;
    check("post_m_valid", 32'(b_m_valid), 32'd0);
    check("post_s_ready", 32'(b_s_ready), 32'd1);
    check("frame_cnt", 32'(b_frame_cnt), 32'(exp_frames));
    check("mismatch_cnt", 32'(b_mismatch_cnt), 32'(exp_mm));
    q_data.delete(); q_mode.delete(); q_tgt.delete(); q_mask.delete(); q_val.delete();
  endtask

  task automatic frame8(input logic [15:0] exp_crc, input logic exp_mm);
    logic [15:0] g;
    int          n;
    g = 16'hFFFF;
    n = q8.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a_s_valid = 1'b1;
      a_s_data  = q8[k];
      a_s_last  = (k == n - 1);
      g = crc_step(g, 64'(q8[k]), 8);
      @(posedge clk);
    end
    @(negedge clk);
    a_s_valid = 1'b0;
    a_s_last  = 1'b0;
    check("a_m_valid", 32'(a_m_valid), 32'd1);
    check("a_m_crc", 32'(a_m_crc), 32'(exp_crc));
    check("a_m_golden", 32'(a_m_golden), 32'(g));
    check("a_m_mismatch", 32'(a_m_mismatch), 32'(exp_mm));
    a_m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_m_ready = 1'b0;
    a_frames  = a_frames + 16'd1;
    check("a_frame_cnt", 32'(a_frame_cnt), 32'(a_frames));
    q8.delete();
  endtask

  initial begin
    reset = 1'b0;
    fault_mode = 2'b00; fault_target = 1'b0; fault_mask = 16'h0; fault_value = 16'h0;
    b_s_valid = 1'b0; b_s_last = 1'b0; b_s_data = 16'h0; b_m_ready = 1'b0;
    a_s_valid = 1'b0; a_s_last = 1'b0; a_s_data = 8'h0; a_m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 32'(b_m_valid), 32'd0);
    check("rst_m_crc", 32'(b_m_crc), 32'd0);
    check("rst_m_golden", 32'(b_m_golden), 32'd0);
    check("rst_m_mismatch", 32'(b_m_mismatch), 32'd0);
    check("rst_frame_cnt", 32'(b_frame_cnt), 32'd0);
    check("rst_mismatch_cnt", 32'(b_mismatch_cnt), 32'd0);
    check("rst_s_ready", 32'(b_s_ready), 32'd1);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Check value "123456789" through 8-bit beats
    for (int i = 0; i < 9; i++) q8.push_back(8'h31 + 8'(i));
    frame8(16'h29B1, 1'b0);

    // Data mask bits above an 8-bit beat have no effect
    set_fault(2, 1'b0, 16'hFF00, 16'h0000);
    q8.push_back(8'h31);
    frame8(crc_step(16'hFFFF, 64'h31, 8), 1'b0);

    // Stuck-at matching the data bit, then contradicting it
    push_beat(16'hA5A5, 1, 1'b0, 16'h0001, 16'h0001);
    frame16(0);
    check("stuck_match_mm", 32'(b_m_mismatch), 32'd0);
    push_beat(16'hA5A5, 1, 1'b0, 16'h0001, 16'h0000);
    frame16(0);
    check("stuck_diff_xor", 32'(b_m_crc ^ b_m_golden), 32'h1021);
    check("stuck_diff_cnt", 32'(b_mismatch_cnt), 32'd1);

    // One-shot on CRC state: corrupts the first beat only, no re-arm on frame 2
    @(negedge clk);
    set_fault(0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) push_beat(16'h1234 + 16'(i), 3, 1'b1, 16'h8000, 16'h0);
    frame16(0);
    check("oneshot_first_mm", 32'(b_m_mismatch), 32'd1);
    for (int i = 0; i < 3; i++) push_beat(16'h1234 + 16'(i), 3, 1'b1, 16'h8000, 16'h0);
    frame16(0);
    check("oneshot_second_mm", 32'(b_m_mismatch), 32'd0);

    // Result backpressure with a pending beat
    push_beat(16'hBEEF, 0, 1'b0, 16'h0, 16'h0);
    push_beat(16'hCAFE, 0, 1'b0, 16'h0, 16'h0);
    frame16(3);

    // Randomised frames
    for (int f = 0; f < 30; f++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++)
        push_beat(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom));
      frame16($urandom_range(0, 2));
    end

    // Reset in the middle of a frame
    @(negedge clk);
    set_fault(0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b_s_valid = 1'b1;
      b_s_data  = 16'($urandom);
      b_s_last  = 1'b0;
    end
    @(negedge clk);
    b_s_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_m_valid", 32'(b_m_valid), 32'd0);
    check("midrst_m_crc", 32'(b_m_crc), 32'd0);
    check("midrst_m_golden", 32'(b_m_golden), 32'd0);
    check("midrst_m_mismatch", 32'(b_m_mismatch), 32'd0);
    check("midrst_frame_cnt", 32'(b_frame_cnt), 32'd0);
    check("midrst_mismatch_cnt", 32'(b_mismatch_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    exp_frames = 16'h0;
    exp_mm     = 16'h0;
    prev_mode  = 0;
    armed      = 1'b0;
    push_beat(16'h0F0F, 0, 1'b0, 16'h0, 16'h0);
    push_beat(16'hF00D, 0, 1'b0, 16'h0, 16'h0);
    frame16(0);

    // Counter saturation via backdoor preload
    @(negedge clk);
    force u_b.r_frame_cnt    = 16'hFFFE;
    force u_b.r_mismatch_cnt = 16'hFFFE;
    @(negedge clk);
    release u_b.r_frame_cnt;
    release u_b.r_mismatch_cnt;
    exp_frames = 16'hFFFE;
    exp_mm     = 16'hFFFE;
    for (int f = 0; f < 2; f++) begin
      push_beat(16'($urandom), 2, 1'b0, 16'h0001, 16'h0);
      frame16(0);
    end
    check("sat_frame_cnt", 32'(b_frame_cnt), 32'hFFFF);
    check("sat_mismatch_cnt", 32'(b_mismatch_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
